// File: rtl/sram_responder.sv
// Block-RAM stand-in for the byte-wide external SRAM, with programmable read latency and
// write-to-read turnaround guard. Optional read/write beat counters: `define SRAM_RESP_STATS_EN.
module sram_responder #(
    parameter int AW     = 16,
    parameter int RD_LAT = 2,
    parameter int TURN   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [20:0] SRAM_ADDR,
    inout  wire  [7:0]  SRAM_DATA,
    input  logic        SRAM_WE_n,
    output logic        rd_valid,
    output logic        oob_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_TURN  = 3'd2,
        S_READ  = 3'd3,
        S_DRIVE = 3'd4
    } state_e;

    localparam logic [3:0] RD_LAST   = 4'(RD_LAT);
    localparam logic [1:0] TURN_LAST = 2'(TURN > 0 ? TURN - 1 : 0);

    logic [7:0]    mem [2**AW];

    state_e        state_q, state_d;
    logic [3:0]    lat_q, lat_d;
    logic [1:0]    turn_q, turn_d;
    logic [20:0]   addr_q;
    logic [7:0]    rd_data_q;
    logic          oob_q, oob_d;
    logic          load_rd;
    logic          in_range;
    logic          addr_chg;
    logic          drive_en;
    logic [AW-1:0] idx;

    assign in_range = (SRAM_ADDR >> AW) == 21'd0;
    assign idx      = SRAM_ADDR[AW-1:0];
    assign addr_chg = SRAM_ADDR != addr_q;

    // Read handshake: no backpressure. rd_valid is high exactly while SRAM_DATA carries read
    // data; it drops combinationally with SRAM_WE_n so the initiator can write at once.
    assign drive_en    = (state_q == S_DRIVE) && SRAM_WE_n;
    assign rd_valid    = drive_en;
    assign SRAM_DATA   = drive_en ? rd_data_q : 8'hzz;
    assign oob_err     = oob_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        turn_d  = turn_q;
        load_rd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!SRAM_WE_n) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                    lat_d   = 4'd1;
                end
            end
            S_WRITE: begin
                if (SRAM_WE_n) begin
                    if (TURN == 0) begin
                        state_d = S_READ;
                        lat_d   = 4'd1;
                    end else begin
                        state_d = S_TURN;
                        turn_d  = 2'd0;
                    end
                end
            end
            S_TURN: begin
                if (!SRAM_WE_n) begin
                    state_d = S_WRITE;
                end else if (turn_q == TURN_LAST) begin
                    state_d = S_READ;
                    lat_d   = 4'd1;
                end else begin
                    turn_d = turn_q + 2'd1;
                end
            end
            S_READ: begin
                if (!SRAM_WE_n) begin
                    state_d = S_WRITE;
                end else if (addr_chg) begin
                    lat_d = 4'd1;
                end else if (lat_q == RD_LAST) begin
                    state_d = S_DRIVE;
                    load_rd = 1'b1;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_DRIVE: begin
                if (!SRAM_WE_n) begin
                    state_d = S_WRITE;
                end else if (addr_chg) begin
                    state_d = S_READ;
                    lat_d   = 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Any access outside the implemented window latches the error until reset.
    assign oob_d = oob_q | (!in_range && (!SRAM_WE_n || load_rd));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lat_q     <= 4'd0;
            turn_q    <= 2'd0;
            addr_q    <= 21'd0;
            rd_data_q <= 8'h00;
            oob_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            turn_q  <= turn_d;
            addr_q  <= SRAM_ADDR;
            oob_q   <= oob_d;
            if (load_rd) begin
                rd_data_q <= in_range ? mem[idx] : 8'hFF;
            end
        end
    end

    // Array is never reset; it behaves like the external part across a reset.
    always_ff @(posedge clk) begin
        if (reset_n && !SRAM_WE_n && in_range) begin
            mem[idx] <= SRAM_DATA;
        end
    end

`ifdef SRAM_RESP_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {15'd0, load_rd};
        wr_cnt_d = wr_cnt_q + {15'd0, ~SRAM_WE_n};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif

endmodule
